fifo_word_packer: RTL

//  Consumer for the 8-bit byte FIFO's read side: drains bytes via read_ctrl/read_data/is_empty,

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_word_packer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, FSM state type and lane parity helper for the byte-FIFO word packer.
package fifo_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } packer_state_t;

  // Even parity bit: makes the total number of ones in {bit, byte} even.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drains an 8-bit FIFO, packs BYTES_PER_WORD bytes per word and hands words off on valid/ready.
// Optional lane parity output enabled by defining FIFO_WORD_PACKER_PARITY_EN.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       in_fifo_read_data,
  input  logic                             in_fifo_is_empty,
  output logic                             out_fifo_read_ctrl,
  input  logic                             in_flush,
  input  logic                             in_word_ready,
  output logic                             out_word_valid,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] out_word_data,
`ifdef FIFO_WORD_PACKER_PARITY_EN
  output logic [BYTES_PER_WORD-1:0]        out_word_parity,
`endif
  output logic [BYTES_PER_WORD-1:0]        out_word_mask
);

  localparam int CNT_W  = $clog2(BYTES_PER_WORD) + 1;
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;

  packer_state_t             r_state;
  logic [CNT_W-1:0]          r_byte_cnt;
  logic                      r_pend;
  logic                      r_flush_pend;
  logic                      r_valid;
  logic [WORD_W-1:0]         r_data;
  logic [BYTES_PER_WORD-1:0] r_mask;

  logic [CNT_W:0]            w_fill_lvl;
  logic                      w_read_ctrl;
  logic [CNT_W-1:0]          w_cnt_cap;
  logic [WORD_W-1:0]         w_data_cap;
  logic [BYTES_PER_WORD-1:0] w_mask_cap;
  logic [BYTES_PER_WORD-1:0] w_lane_hit;
  logic                      w_word_full;
  logic                      w_flush_set;
  logic                      w_flush_go;

`ifdef FIFO_WORD_PACKER_PARITY_EN
  logic [BYTES_PER_WORD-1:0] r_parity;
  logic [BYTES_PER_WORD-1:0] w_parity_cap;
`endif

  // Bytes already collected plus the one whose read data arrives this cycle.
  assign w_fill_lvl  = {1'b0, r_byte_cnt} + (CNT_W+1)'(r_pend);
  assign w_read_ctrl = (r_state == FILL) & ~in_fifo_is_empty & ~r_flush_pend &
                       (w_fill_lvl < (CNT_W+1)'(BYTES_PER_WORD));
  assign w_flush_set = in_flush & (w_fill_lvl != (CNT_W+1)'(0));
  assign w_flush_go  = r_flush_pend & ~r_pend;
  assign w_word_full = (w_cnt_cap == CNT_W'(BYTES_PER_WORD));

  // Lane write decode: the returning FIFO byte lands in lane byte_cnt.
  always_comb begin
    w_lane_hit = '0;
    w_data_cap = r_data;
    w_mask_cap = r_mask;
`ifdef FIFO_WORD_PACKER_PARITY_EN
    w_parity_cap = r_parity;
`endif
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      w_lane_hit[i] = r_pend & (r_byte_cnt == CNT_W'(i));
      w_data_cap[i*BYTE_W +: BYTE_W] = w_lane_hit[i] ? in_fifo_read_data
                                                      : r_data[i*BYTE_W +: BYTE_W];
      w_mask_cap[i] = w_lane_hit[i] | r_mask[i];
`ifdef FIFO_WORD_PACKER_PARITY_EN
      w_parity_cap[i] = w_lane_hit[i] ? even_parity(in_fifo_read_data) : r_parity[i];
`endif
    end
    w_cnt_cap = r_byte_cnt + CNT_W'(r_pend);
  end

  // FILL/DRAIN sequencing and word assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_byte_cnt   <= '0;
      r_pend       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_mask       <= '0;
`ifdef FIFO_WORD_PACKER_PARITY_EN
      r_parity     <= '0;
`endif
    end else begin
      r_pend <= w_read_ctrl;
      case (r_state)
        FILL: begin
          r_data     <= w_data_cap;
          r_mask     <= w_mask_cap;
          r_byte_cnt <= w_cnt_cap;
`ifdef FIFO_WORD_PACKER_PARITY_EN
          r_parity   <= w_parity_cap;
`endif
          if (w_word_full || w_flush_go) begin
            r_state      <= DRAIN;
            r_valid      <= 1'b1;
            r_flush_pend <= 1'b0;
          end else if (w_flush_set) begin
            r_flush_pend <= 1'b1;
          end
        end
        DRAIN: begin
          if (in_word_ready) begin
            r_state    <= FILL;
            r_valid    <= 1'b0;
            r_byte_cnt <= '0;
            r_data     <= '0;
            r_mask     <= '0;
`ifdef FIFO_WORD_PACKER_PARITY_EN
            r_parity   <= '0;
`endif
          end
        end
        default: begin
          r_state <= FILL;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_fifo_read_ctrl = w_read_ctrl;
  assign out_word_valid     = r_valid;
  assign out_word_data      = r_data;
  assign out_word_mask      = r_mask;
`ifdef FIFO_WORD_PACKER_PARITY_EN
  assign out_word_parity    = r_parity;
`endif

endmodule
